// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST image streamer.
package mnist_pkg;

    localparam int TOTAL_PIXELS = 784;
    localparam int PIXEL_W      = 8;
    localparam int INDEX_W      = 4;
    localparam int PIX_CNT_W    = $clog2(TOTAL_PIXELS + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_RESULT
    } streamer_state_t;

endpackage

// File: rtl/mnist_image_streamer_if.sv
// Image-memory read port plus MLP pixel/result handshake seen by the streamer.
interface mnist_image_streamer_if
    import mnist_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd_en;
    logic [PIXEL_W-1:0] mem_rdata;
    logic               input_en;
    logic [PIXEL_W-1:0] pixel_out;
    logic               mlp_output_en;
    logic [INDEX_W-1:0] mlp_index;

    modport master (
        output mem_addr, mem_rd_en, input_en, pixel_out,
        input  mem_rdata, mlp_output_en, mlp_index
    );

    modport slave (
        input  mem_addr, mem_rd_en, input_en, pixel_out,
        output mem_rdata, mlp_output_en, mlp_index
    );
endinterface

// File: rtl/mnist_stream_addr_gen.sv
// Issues exactly TOTAL_PIXELS back-to-back reads from a latched image base address.
module mnist_stream_addr_gen
    import mnist_pkg::*;
#(
    parameter int ADDR_W = 14
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              rd_vld_d1,
    output logic              last_issue
);
    logic [ADDR_W-1:0]    base_reg;
    logic [PIX_CNT_W-1:0] rd_cnt_reg;

    // rd_cnt_reg counts reads already issued, so it doubles as the next pixel offset
    assign last_issue = mem_rd_en && (rd_cnt_reg == PIX_CNT_W'(TOTAL_PIXELS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg   <= '0;
            rd_cnt_reg <= '0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            rd_vld_d1  <= 1'b0;
        end else begin
            rd_vld_d1 <= mem_rd_en;
            if (load) begin
                base_reg   <= base_in;
                mem_addr   <= base_in;
                mem_rd_en  <= 1'b1;
                rd_cnt_reg <= PIX_CNT_W'(1);
            end else if (mem_rd_en) begin
                if (last_issue) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    mem_addr   <= base_reg + ADDR_W'(rd_cnt_reg);
                    rd_cnt_reg <= rd_cnt_reg + PIX_CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/mnist_image_streamer.sv
// Streams one stored image to the MLP as pixel beats, then captures the inference result.
module mnist_image_streamer
    import mnist_pkg::*;
#(
    parameter int NUM_IMAGES  = 16,
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 4096
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [INDEX_W-1:0]  img_sel,
    mnist_image_streamer_if.master bus,
    output logic                busy,
    output logic                result_valid,
    output logic [INDEX_W-1:0]  result_index,
    output logic                timeout_err,
    output logic                sel_err
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    streamer_state_t    state_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic               oe_prev_reg;
    logic               input_en_reg;
    logic [PIXEL_W-1:0] pixel_reg;

    logic               img_ok;
    logic               accept;
    logic               mlp_rise;
    logic [ADDR_W-1:0]  base_next;
    logic [ADDR_W-1:0]  ag_addr;
    logic               ag_rd_en;
    logic               rd_vld_d1;
    logic               last_issue;

    assign img_ok    = {{(32-INDEX_W){1'b0}}, img_sel} < 32'(NUM_IMAGES);
    assign accept    = (state_reg == IDLE) && start && img_ok;
    assign base_next = ADDR_W'(img_sel) * ADDR_W'(TOTAL_PIXELS);
    // The MLP holds output_en high after a result, so only a fresh 0->1 counts
    assign mlp_rise  = bus.mlp_output_en && !oe_prev_reg;

    mnist_stream_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .base_in    (base_next),
        .mem_addr   (ag_addr),
        .mem_rd_en  (ag_rd_en),
        .rd_vld_d1  (rd_vld_d1),
        .last_issue (last_issue)
    );

    assign bus.mem_addr  = ag_addr;
    assign bus.mem_rd_en = ag_rd_en;
    assign bus.input_en  = input_en_reg;
    assign bus.pixel_out = pixel_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            oe_prev_reg  <= 1'b0;
            input_en_reg <= 1'b0;
            pixel_reg    <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_index <= '0;
            timeout_err  <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            sel_err      <= 1'b0;
            oe_prev_reg  <= bus.mlp_output_en;
            input_en_reg <= rd_vld_d1;
            if (rd_vld_d1) begin
                pixel_reg <= bus.mem_rdata;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (img_ok) begin
                            busy        <= 1'b1;
                            timeout_err <= 1'b0;
                            state_reg   <= READ;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (last_issue) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final beat is in flight once the read-valid pipe empties
                    if (!rd_vld_d1) begin
                        timer_reg <= '0;
                        state_reg <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    if (mlp_rise) begin
                        result_index <= bus.mlp_index;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (timer_reg == TMR_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_image_streamer.sv
// Directed bench: image memory and MLP models, pixel/result scoreboards, one line per check failure.
module tb_mnist_image_streamer;
    import mnist_pkg::*;

    localparam int NIMG  = 12;   // smaller than 16 so a 4-bit img_sel can be out of range
    localparam int AW    = 14;
    localparam int TOUT  = 64;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] img_sel;
    logic       busy, result_valid, timeout_err, sel_err;
    logic [3:0] result_index;

    mnist_image_streamer_if #(.ADDR_W(AW)) bus ();

    mnist_image_streamer #(
        .NUM_IMAGES  (NIMG),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .img_sel      (img_sel),
        .bus          (bus),
        .busy         (busy),
        .result_valid (result_valid),
        .result_index (result_index),
        .timeout_err  (timeout_err),
        .sel_err      (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:NIMG*TOTAL_PIXELS-1];

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic logic [7:0] mem_val(input int a);
        return 8'(a % 256 + (a / TOTAL_PIXELS) * 37);
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc = 0, beat_cnt, rd_cnt, first_addr, last_addr, first_beat, start_cyc;
    int res_cnt, sel_cnt, fall_cyc, tout_cyc;
    int cd_rise = 0, cd_drop = 0, cfg_rise, cfg_drop, pend_idx;
    logic [7:0] last_pix = 8'd0;
    bit prev_in = 1'b0;
    int pxq[$];
    int res_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, run scoreboards and the MLP model
    task automatic tick();
        int exp;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            last_pix = bus.pixel_out;
            prev_in  = 1'b0;
            return;
        end
        if (bus.input_en) begin
            beat_cnt++;
            if (first_beat < 0) first_beat = cyc;
            exp = (pxq.size() > 0) ? pxq.pop_front() : 999;
            check("pixel", 32'(bus.pixel_out), exp);
        end else begin
            check("pixel_hold", 32'(bus.pixel_out), 32'(last_pix));
        end
        last_pix = bus.pixel_out;
        if (bus.mem_rd_en) begin
            rd_cnt++;
            if (first_addr < 0) first_addr = int'(bus.mem_addr);
            last_addr = int'(bus.mem_addr);
        end
        if (prev_in && !bus.input_en) begin
            fall_cyc = cyc;
            cd_rise  = cfg_rise;
            cd_drop  = cfg_drop;
        end
        prev_in = bus.input_en;
        if (cd_drop > 0) begin
            cd_drop--;
            if (cd_drop == 0) bus.mlp_output_en = 1'b0;
        end
        if (cd_rise > 0) begin
            cd_rise--;
            if (cd_rise == 0) begin
                bus.mlp_output_en = 1'b1;
                bus.mlp_index     = 4'(pend_idx);
            end
        end
        if (result_valid) begin
            res_cnt++;
            exp = (res_q.size() > 0) ? res_q.pop_front() : 99;
            check("result_index", 32'(result_index), exp);
        end
        if (timeout_err && tout_cyc < 0) tout_cyc = cyc;
        if (sel_err) sel_cnt++;
    endtask

    task automatic run_stream(input int sel, input int rise_after, input int drop_after,
                              input int idx, input bit hold_high, input bit stray,
                              input bit expect_res, input int abort_at);
        int n;
        beat_cnt = 0; rd_cnt = 0; first_addr = -1; last_addr = -1; first_beat = -1;
        res_cnt = 0; fall_cyc = -1; tout_cyc = -1;
        pxq.delete();
        for (int j = 0; j < TOTAL_PIXELS; j++) pxq.push_back(int'(mem_val(sel*TOTAL_PIXELS + j)));
        if (expect_res) res_q.push_back(idx);
        pend_idx = idx; cfg_rise = rise_after; cfg_drop = drop_after;
        if (!hold_high) bus.mlp_output_en = 1'b0;
        img_sel = 4'(sel);
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        check("busy_on_start", 32'(busy), 1);
        check("timeout_clr_on_start", 32'(timeout_err), 0);
        n = 0;
        while (busy && n < 4000) begin
            tick();
            n++;
            if (abort_at > 0 && beat_cnt == abort_at) return;
            start = stray && (beat_cnt == 100);
        end
        start = 1'b0;
        check("stream_done_in_bound", 32'(n < 4000), 1);
        check("beat_count", beat_cnt, TOTAL_PIXELS);
        check("first_beat_latency", first_beat - start_cyc, 3);
        check("read_count", rd_cnt, TOTAL_PIXELS);
        check("first_addr", first_addr, sel*TOTAL_PIXELS);
        check("last_addr", last_addr, sel*TOTAL_PIXELS + TOTAL_PIXELS - 1);
        check("pixels_left", pxq.size(), 0);
        check("result_pulses", res_cnt, expect_res ? 1 : 0);
        check("busy_after", 32'(busy), 0);
    endtask

    logic any_out;

    initial begin
        for (int a = 0; a < NIMG*TOTAL_PIXELS; a++) mem[a] = mem_val(a);
        start = 1'b0; img_sel = 4'd0;
        bus.mlp_output_en = 1'b0; bus.mlp_index = 4'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        any_out = busy | result_valid | timeout_err | sel_err | (|result_index) |
                  (|bus.mem_addr) | bus.mem_rd_en | bus.input_en | (|bus.pixel_out);
        check("async_reset_outputs", 32'(any_out), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        sel_cnt = 0;
        any_out = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            any_out = any_out | busy | result_valid | timeout_err | sel_err | (|result_index) |
                      (|bus.mem_addr) | bus.mem_rd_en | bus.input_en | (|bus.pixel_out);
        end
        check("idle_outputs_zero", 32'(any_out), 0);

        // Nominal: image 0, MLP answers 7 fifty cycles after the last beat
        run_stream(0, 50, -1, 7, 1'b0, 1'b0, 1'b1, 0);
        check("nominal_result_index", 32'(result_index), 7);
        check("nominal_last_pixel", 32'(bus.pixel_out), 15);
        check("nominal_no_timeout", 32'(timeout_err), 0);

        // Addressing on image 2
        run_stream(2, 10, -1, 5, 1'b0, 1'b0, 1'b1, 0);
        check("img2_result_index", 32'(result_index), 5);

        // First out-of-range selector is rejected with a one-cycle pulse
        img_sel = 4'(NIMG);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sel_err_pulse", 32'(sel_err), 1);
        check("sel_err_busy", 32'(busy), 0);
        tick();
        check("sel_err_cleared", 32'(sel_err), 0);
        check("sel_err_still_idle", 32'(busy), 0);
        check("sel_err_no_read", 32'(bus.mem_rd_en), 0);

        // Sticky output_en high on entry, stray start mid-stream, last valid image
        bus.mlp_output_en = 1'b1;
        bus.mlp_index     = 4'd9;
        run_stream(NIMG-1, 10, 5, 3, 1'b1, 1'b1, 1'b1, 0);
        check("sticky_result_index", 32'(result_index), 3);

        // Timeout: output_en never rises
        run_stream(0, -1, -1, 0, 1'b0, 1'b0, 1'b0, 0);
        check("timeout_flag", 32'(timeout_err), 1);
        check("timeout_latency", tout_cyc - fall_cyc, TOUT);
        check("timeout_keeps_index", 32'(result_index), 3);

        // Next accepted start clears the sticky timeout flag
        run_stream(3, 20, -1, 4, 1'b0, 1'b0, 1'b1, 0);
        check("after_timeout_index", 32'(result_index), 4);
        check("after_timeout_flag", 32'(timeout_err), 0);

        // Reset in the middle of a stream, then a full restart of the same image
        run_stream(1, -1, -1, 0, 1'b0, 1'b0, 1'b0, 300);
        check("abort_at_beat", beat_cnt, 300);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_input_en", 32'(bus.input_en), 0);
        check("midreset_rd_en", 32'(bus.mem_rd_en), 0);
        check("midreset_busy", 32'(busy), 0);
        cd_rise = 0; cd_drop = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_stream(1, 15, -1, 2, 1'b0, 1'b0, 1'b1, 0);
        check("restart_result_index", 32'(result_index), 2);
        check("results_left", res_q.size(), 0);
        check("sel_err_count", sel_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
